alu_issue: RTL
==============

Name: alu_issue

Overview:
- Producer side of the ALU operand interface. It accepts instruction words over a valid/ready handshake and reads operands from an internal register file.
- It drives registered val1/val2/aluop/is_alu_op into the combinational ALU, then writes the returned ALU result back to the destination register one cycle later.
- Includes result bypass for back-to-back dependencies and a divide-by-zero fault state.

Parameters:
- NREGS, 16, register file depth; power of two; register index width is log2(NREGS), fixed at 4 bits for the instruction format.
- OP_DIV, 5'd6, aluop encoding that is checked for divide-by-zero.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst  input  32  instruction word.
- inst_valid  input  1  inst is valid this cycle.
- inst_ready  output  1  block accepts inst this cycle.
- val1  output  32  ALU operand 1 (registered).
- val2  output  32  ALU operand 2 (registered).
- aluop  output  5  ALU operation (registered).
- is_alu_op  output  1  operands valid for the ALU (registered).
- alu_result  input  32  combinational result from the ALU for the current val1/val2/aluop.
- fault  output  1  divide-by-zero fault latched.
- fault_clr  input  1  clears the fault.
- dbg_addr  input  4  debug read index.
- dbg_data  output  32  combinational read of regfile[dbg_addr].

Behaviour:
- Reset: async, active-low; the polarity and synchronicity are fixed.
  - All regfile entries are 0.
  - val1, val2, aluop are 0; is_alu_op is 0; fault is 0.
  - Write-back pending flag (wb_v) is 0; state is RUN.
  - Reset asserted mid-operation discards any pending write-back.
- Instruction format:
  - [31:27] aluop.
  - [26] I flag.
  - [25:22] rd.
  - [21:18] rs1.
  - [17:14] rs2 (R form only).
  - [15:0] imm16 (I form only).
- Operand selection:
  - val1 = R[rs1].
  - val2 = I ? {16'd0, imm16} : R[rs2].
- Handshake:
  - An instruction is accepted on a rising edge where inst_valid && inst_ready.
  - inst_ready = (state == RUN).
  - inst_valid does not depend on inst_ready.
- Issue (accept edge):
  - val1, val2, aluop are loaded; is_alu_op = 1; wb_rd = rd; wb_v = 1.
  - On any other edge: is_alu_op = 0 and wb_v = 0; val1/val2/aluop hold.
- Write-back:
  - On the edge after issue, while wb_v = 1, R[wb_rd] <= alu_result.
  - Issue-to-regfile-update latency is 1 cycle after issue.
- Bypass:
  - If wb_v = 1 and a source index (rs1, or rs2 when I = 0) equals wb_rd, that operand takes alu_result instead of the regfile.
  - Back-to-back dependent instructions therefore issue every cycle with no stall.
- Simultaneous write-back and read of the same register: the bypass wins, so the operand is the new value.
- Divide-by-zero:
  - Checked at accept, on the selected val2 after bypass.
  - If aluop == OP_DIV and the selected val2 == 0:
    - The instruction is still issued and written back (the ALU result is whatever the ALU returns).
    - fault <= 1 and state <= FAULT.
- FSM:
  - RUN -> FAULT on a divide-by-zero accept.
  - FAULT -> RUN on fault_clr = 1; fault <= 0 on the same edge.
  - fault_clr in RUN has no effect.
  - In FAULT, inst_ready = 0; a pending write-back still completes.
- dbg_data is combinational from the regfile and does not see the bypass.

Optional Feature:
- Macro: ALU_ISSUE_R0_ZERO_EN.
- Defined:
  - Register 0 always reads as 0, including on the debug port.
  - Writes to rd = 0 are dropped.
  - Bypass never applies when the source index is 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then dbg_addr sweep 0..15 -> all dbg_data = 0; inst_ready = 1; is_alu_op = 0; fault = 0.
- I-form MOVL (aluop = MOVL encoding) with rd = 3, imm16 = 0x1234, bench ALU model attached -> next cycle val2 = 0x00001234, is_alu_op = 1; after the following edge, R3 = 0x00001234.
- Back-to-back dependency: R1 = 5, R2 = 7. ADD r3 = r1 + r2, then next cycle ADD r4 = r3 + r1 -> second issue has val1 = 12 (bypassed), val2 = 5; R4 = 17.
- DIV with rs2 = R0 = 0 (macro undefined, R0 = 0) -> fault = 1 the cycle after accept and inst_ready = 0. Hold inst_valid for 3 cycles -> nothing accepted. Pulse fault_clr -> fault = 0 and inst_ready = 1 on the next cycle.
- Assert rst_n low asynchronously one cycle after issue, before write-back -> R[rd] stays 0 and is_alu_op drops immediately.
- With ALU_ISSUE_R0_ZERO_EN: MOVL rd = 0, imm16 = 0xFFFF, then MOV r5 = r0 -> val1 = 0 and R5 = 0.

Source files
------------

// File: rtl/alu_issue.sv
// Issue stage feeding a combinational ALU: register file, operand bypass, write-back, divide-by-zero fault.
// Optional: define ALU_ISSUE_R0_ZERO_EN to hard-wire register 0 to zero.
module alu_issue #(
  parameter int unsigned NREGS  = 16,
  parameter logic [4:0]  OP_DIV = 5'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [4:0]  aluop,
  output logic        is_alu_op,
  input  logic [31:0] alu_result,
  output logic        fault,
  input  logic        fault_clr,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] val1_q, val1_d;
  logic [31:0] val2_q, val2_d;
  logic [4:0]  aluop_q, aluop_d;
  logic        is_alu_op_q;
  logic        wb_v_q;
  logic [3:0]  wb_rd_q, wb_rd_d;

  logic [4:0]  op_s;
  logic        imm_form_s;
  logic [3:0]  rd_s, rs1_s, rs2_s;
  logic [15:0] imm_s;
  logic [31:0] rf_rd1_s, rf_rd2_s;
  logic        byp1_s, byp2_s;
  logic [31:0] opnd1_s, opnd2_s;
  logic        accept_s, div0_s, wb_we_s;

  assign op_s       = inst[31:27];
  assign imm_form_s = inst[26];
  assign rd_s       = inst[25:22];
  assign rs1_s      = inst[21:18];
  assign rs2_s      = inst[17:14];
  assign imm_s      = inst[15:0];

  assign inst_ready = (state_q == ST_RUN);
  assign accept_s   = inst_valid && inst_ready;

  // Register file reads, bypass selection and write enable
  always_comb begin
    rf_rd1_s = rf_q[rs1_s];
    rf_rd2_s = rf_q[rs2_s];
    byp1_s   = wb_v_q && (rs1_s == wb_rd_q);
    byp2_s   = wb_v_q && (rs2_s == wb_rd_q);
    wb_we_s  = wb_v_q;
    dbg_data = rf_q[dbg_addr];
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (rs1_s == 4'd0) begin
      rf_rd1_s = 32'd0;
      byp1_s   = 1'b0;
    end else begin
      byp1_s   = byp1_s;
    end
    if (rs2_s == 4'd0) begin
      rf_rd2_s = 32'd0;
      byp2_s   = 1'b0;
    end else begin
      byp2_s   = byp2_s;
    end
    if (wb_rd_q == 4'd0) begin
      wb_we_s = 1'b0;
    end else begin
      wb_we_s = wb_v_q;
    end
    if (dbg_addr == 4'd0) begin
      dbg_data = 32'd0;
    end else begin
      dbg_data = rf_q[dbg_addr];
    end
`endif
  end

  // Operand selection; the in-flight result overrides a stale register value
  always_comb begin
    opnd1_s = byp1_s ? alu_result : rf_rd1_s;
    if (imm_form_s) begin
      opnd2_s = {16'd0, imm_s};
    end else if (byp2_s) begin
      opnd2_s = alu_result;
    end else begin
      opnd2_s = rf_rd2_s;
    end
    div0_s = accept_s && (op_s == OP_DIV) && (opnd2_s == 32'd0);
  end

  // Issue register next-state
  always_comb begin
    val1_d  = val1_q;
    val2_d  = val2_q;
    aluop_d = aluop_q;
    wb_rd_d = wb_rd_q;
    if (accept_s) begin
      val1_d  = opnd1_s;
      val2_d  = opnd2_s;
      aluop_d = op_s;
      wb_rd_d = rd_s;
    end else begin
      val1_d  = val1_q;
    end
  end

  // Fault FSM next-state
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_RUN: begin
        if (div0_s) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_RUN;
          fault_d = 1'b0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_RUN;
        fault_d = 1'b0;
      end
    endcase
  end

  // Fault FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Issue and write-back pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val1_q      <= 32'd0;
      val2_q      <= 32'd0;
      aluop_q     <= 5'd0;
      is_alu_op_q <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= 4'd0;
    end else begin
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      aluop_q     <= aluop_d;
      is_alu_op_q <= accept_s;
      wb_v_q      <= accept_s;
      wb_rd_q     <= wb_rd_d;
    end
  end

  // Register file write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (wb_we_s) begin
      rf_q[wb_rd_q] <= alu_result;
    end
  end

  assign val1      = val1_q;
  assign val2      = val2_q;
  assign aluop     = aluop_q;
  assign is_alu_op = is_alu_op_q;
  assign fault     = fault_q;

endmodule
